mul_iter: RTL and testbench



---
 rtl/mul_iter.sv | 137 +++++++++++++
 tb/tb_mul_iter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative 32x32 multiplier (MUL/UMULL/SMULL) with start/busy/done handshake
module mul_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mul_control,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic [3:0]  flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_UMULL = 3'b110;
    localparam logic [2:0] OP_SMULL = 3'b111;

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        sign_q, sign_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [3:0]  flags_q, flags_d;

    logic        op_valid;
    logic        is_smull;
    logic        accept;
    logic [31:0] abs_a, abs_b;
    logic [63:0] product;

    assign op_valid = (mul_control == OP_MUL) || (mul_control == OP_UMULL) ||
                      (mul_control == OP_SMULL);
    assign is_smull = (mul_control == OP_SMULL);
    assign accept   = start && op_valid && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Two's-complement negate of 0x80000000 wraps to itself, which is the
    // correct unsigned magnitude.
    assign abs_a = (is_smull && a[31]) ? (~a + 32'd1) : a;
    assign abs_b = (is_smull && b[31]) ? (~b + 32'd1) : b;

    assign product = sign_q ? (~acc_q + 64'd1) : acc_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_d   = sign_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        flags_d  = flags_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d     = mul_control;
                    sign_d   = is_smull && (a[31] ^ b[31]);
                    mcand_d  = {32'd0, abs_a};
                    mplier_d = abs_b;
                    acc_d    = 64'd0;
                    cnt_d    = 5'd0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = {mcand_q[62:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                lo_d = product[31:0];
                if (op_q == OP_MUL) begin
                    hi_d    = 32'd0;
                    flags_d = {product[31], (product[31:0] == 32'd0), 2'b00};
                end else begin
                    hi_d    = product[63:32];
                    flags_d = {product[63], (product == 64'd0), 2'b00};
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            sign_q   <= 1'b0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            cnt_q    <= 5'd0;
            lo_q     <= 32'd0;
            hi_q     <= 32'd0;
            flags_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            flags_q  <= flags_d;
        end
    end

    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_mul_iter.sv
// tb/tb_mul_iter.sv - scoreboard bench for mul_iter against an arithmetic reference model
module tb_mul_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mul_control;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result_lo, result_hi;
    logic [3:0]  flags;

    mul_iter dut (
        .clk(clk), .reset(reset), .start(start), .mul_control(mul_control),
        .a(a), .b(b), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  fl;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_fail = 0;
    int   cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        if (act === req) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit integer multiplication, signed or unsigned.
    task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] lo, output logic [31:0] hi, output logic [3:0] fl);
        logic [63:0] p;
        if (op == 3'b111) p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        else              p = {32'd0, x} * {32'd0, y};
        lo = p[31:0];
        if (op == 3'b101) begin
            hi = 32'd0;
            fl = {lo[31], lo == 32'd0, 2'b00};
        end else begin
            hi = p[63:32];
            fl = {hi[31], p == 64'd0, 2'b00};
        end
    endtask

    // Monitor: pops expectations whenever done is presented.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy && done) begin
                n_fail++;
                $display("FAIL busy_done_overlap: busy=%b done=%b", busy, done);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: done=1 with no op outstanding");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_lo", {32'd0, result_lo}, {32'd0, e.lo});
                    check("result_hi", {32'd0, result_hi}, {32'd0, e.hi});
                    check("flags", {60'd0, flags}, {60'd0, e.fl});
                    check("latency", 64'(cycle - e.cyc), 64'd33);
                end
            end
        end
    end

    // Waits for a free slot (IDLE or DONE) unless called right at one, then presents start.
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input bit sync);
        exp_t e;
        int   guard = 0;
        if (sync) @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL issue_timeout: busy stuck at %b", busy);
        end
        start = 1'b1; mul_control = op; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom; mul_control = 3'($urandom);
        if (op[2] && op != 3'b100) begin
            model(op, x, y, e.lo, e.hi, e.fl);
            e.cyc = cycle;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_done();
        int guard = 0;
        @(negedge clk);
        while (!done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("wait_done", {63'd0, done}, 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [31:0] plo, phi;
    logic [3:0]  pfl;

    initial begin
        reset = 1'b1; start = 1'b0; mul_control = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_lo", {32'd0, result_lo}, 64'd0);
        check("rst_hi", {32'd0, result_hi}, 64'd0);
        check("rst_flags", {60'd0, flags}, 64'd0);

        issue(3'b101, 32'h7, 32'h6, 1);
        issue(3'b101, 32'h00010000, 32'h00010000, 1);
        issue(3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        issue(3'b111, 32'hFFFFFFFF, 32'h2, 1);
        issue(3'b111, 32'h80000000, 32'h80000000, 1);
        issue(3'b111, 32'h0, 32'h80000000, 1);
        drain();
        check("smull_zero_flags", {60'd0, flags}, 64'h4);

        // Starts during busy must be ignored.
        issue(3'b110, 32'h12345678, 32'h9ABCDEF0, 1);
        repeat (4) @(negedge clk);
        start = 1'b1; mul_control = 3'b101; a = 32'h3; b = 32'h5;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1; mul_control = 3'b111; a = 32'hDEAD; b = 32'hBEEF;
        @(negedge clk); start = 1'b0;
        drain();

        // Invalid op code in IDLE.
        repeat (2) @(negedge clk);
        issue(3'b010, 32'h5, 32'h5, 1);
        check("invalid_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("invalid_idle", {63'd0, busy | done}, 64'd0);

        // Reset mid-CALC aborts without a done pulse.
        issue(3'b110, 32'hCAFEBABE, 32'h11111111, 1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_lo", {32'd0, result_lo}, 64'd0);
        check("abort_hi", {32'd0, result_hi}, 64'd0);
        check("abort_flags", {60'd0, flags}, 64'd0);
        repeat (40) @(negedge clk);

        // Back-to-back restart from DONE.
        issue(3'b111, 32'hFFFF0000, 32'h00001234, 1);
        model(3'b111, 32'hFFFF0000, 32'h00001234, plo, phi, pfl);
        wait_done();
        issue(3'b110, 32'h0BADF00D, 32'h76543210, 0);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        check("b2b_done", {63'd0, done}, 64'd0);
        check("b2b_hold_lo", {32'd0, result_lo}, {32'd0, plo});
        check("b2b_hold_hi", {32'd0, result_hi}, {32'd0, phi});
        drain();

        for (int i = 0; i < 30; i++) begin
            logic [2:0] op;
            op = 3'b101 + 3'($urandom_range(0, 2));
            issue(op, $urandom, $urandom, 1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
